// File: rtl/demux_channel_deserializer.sv
// Per-channel serial-to-parallel assembly behind the 1-to-4 bit demux.
// Completed words are merged onto one valid/ready stream by a round-robin arbiter.
module demux_channel_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic [1:0]       sel,
   input  logic [3:0]       demux_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_chan,
   output logic [3:0]       overflow,
   input  logic             clr_overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr_q   [4];
   logic [WIDTH-1:0] sr_d   [4];
   logic [CW-1:0]    cnt_q  [4];
   logic [CW-1:0]    cnt_d  [4];
   logic [WIDTH-1:0] hold_q [4];
   logic [WIDTH-1:0] hold_d [4];
   logic [3:0]       hold_full_q, hold_full_d;
   logic [1:0]       last_grant_q, last_grant_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       out_chan_q, out_chan_d;
   logic [3:0]       overflow_q, overflow_d;

   logic             out_free;
   logic             grant_vld;
   logic [1:0]       grant_idx;
   logic [1:0]       cand;
   logic             bit_in;

   always_comb begin
      sr_d         = sr_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      last_grant_d = last_grant_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_chan_d   = out_chan_q;
      overflow_d   = clr_overflow ? 4'b0000 : overflow_q;
      out_free     = !out_valid_q || out_ready;
      grant_vld    = 1'b0;
      grant_idx    = 2'd0;
      cand         = 2'd0;
      bit_in       = demux_out[sel];

      for (int k = 1; k <= 4; k++) begin
         cand = last_grant_q + 2'(k);
         if (out_free && !grant_vld && hold_full_q[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end

      if (grant_vld) begin
         out_valid_d            = 1'b1;
         out_data_d             = hold_q[grant_idx];
         out_chan_d             = grant_idx;
         hold_full_d[grant_idx] = 1'b0;
         last_grant_d           = grant_idx;
      end else if (out_free) begin
         out_valid_d = 1'b0;
      end

      // Drain is applied above first, so a hold emptied this cycle can be refilled.
      if (bit_valid) begin
         sr_d[sel] = {sr_q[sel][WIDTH-2:0], bit_in};
         if (cnt_q[sel] == CNT_LAST) begin
            cnt_d[sel] = '0;
            if (!hold_full_d[sel]) begin
               hold_d[sel]      = sr_d[sel];
               hold_full_d[sel] = 1'b1;
            end else begin
               overflow_d[sel] = 1'b1;
            end
         end else begin
            cnt_d[sel] = cnt_q[sel] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 4; c++) begin
            sr_q[c]   <= '0;
            cnt_q[c]  <= '0;
            hold_q[c] <= '0;
         end
         hold_full_q  <= 4'b0000;
         last_grant_q <= 2'd3;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_chan_q   <= 2'd0;
         overflow_q   <= 4'b0000;
      end else begin
         for (int c = 0; c < 4; c++) begin
            sr_q[c]   <= sr_d[c];
            cnt_q[c]  <= cnt_d[c];
            hold_q[c] <= hold_d[c];
         end
         hold_full_q  <= hold_full_d;
         last_grant_q <= last_grant_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_chan_q   <= out_chan_d;
         overflow_q   <= overflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_demux_channel_deserializer.sv
// Bench for demux_channel_deserializer: directed scenarios plus random traffic,
// every cycle compared against a word-level reference model.
module tb_demux_channel_deserializer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             bit_valid = 1'b0;
   logic [1:0]       sel = 2'd0;
   logic [3:0]       demux_out = 4'd0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_chan;
   logic [3:0]       overflow;
   logic             clr_overflow = 1'b0;

   demux_channel_deserializer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .bit_valid(bit_valid), .sel(sel),
      .demux_out(demux_out), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_chan(out_chan), .overflow(overflow),
      .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: bits collected per channel, one pending word per channel,
   // and a single output slot served in rotating order.
   int unsigned m_nbits [4];
   int unsigned m_acc   [4];
   int unsigned m_hold  [4];
   bit          m_full  [4];
   int          m_last;
   bit          m_oval;
   int unsigned m_odata;
   int          m_ochan;
   bit [3:0]    m_ov;

   logic [9:0]  got_q[$];

   task automatic m_reset();
      for (int c = 0; c < 4; c++) begin
         m_nbits[c] = 0; m_acc[c] = 0; m_hold[c] = 0; m_full[c] = 0;
      end
      m_last = 3; m_oval = 0; m_odata = 0; m_ochan = 0; m_ov = 0;
   endtask

   task automatic m_step();
      bit free;
      int g;
      int s;
      int unsigned b;
      free = !m_oval || out_ready;
      g = -1;
      if (free)
         for (int k = 1; k <= 4; k++)
            if (g < 0 && m_full[(m_last + k) % 4]) g = (m_last + k) % 4;
      if (clr_overflow) m_ov = 0;
      if (g >= 0) begin
         m_odata = m_hold[g]; m_ochan = g; m_oval = 1; m_full[g] = 0; m_last = g;
      end else if (free) begin
         m_oval = 0;
      end
      if (bit_valid) begin
         s = sel;
         b = (demux_out >> s) & 1;
         m_acc[s] = ((m_acc[s] * 2) + b) % (1 << WIDTH);
         m_nbits[s]++;
         if (m_nbits[s] == WIDTH) begin
            m_nbits[s] = 0;
            if (!m_full[s]) begin
               m_hold[s] = m_acc[s]; m_full[s] = 1;
            end else begin
               m_ov[s] = 1'b1;
            end
         end
      end
   endtask

   task automatic cmp_outputs(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'(m_oval));
      chk({tag, "_data"},  32'(out_data),  m_odata);
      chk({tag, "_chan"},  32'(out_chan),  32'(m_ochan));
      chk({tag, "_ovf"},   32'(overflow),  32'(m_ov));
   endtask

   // One clock: model advances on current inputs, DUT is sampled 1ns after the edge.
   task automatic step(input string tag);
      if (out_valid && out_ready) got_q.push_back({out_chan, out_data});
      m_step();
      @(posedge clk);
      #1;
      cmp_outputs(tag);
      bit_valid = 1'b0;
      clr_overflow = 1'b0;
   endtask

   task automatic send_bit(input int ch, input bit b, input string tag);
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      d[ch] = b;
      bit_valid = 1'b1; sel = 2'(ch); demux_out = d;
      step(tag);
   endtask

   task automatic send_word(input int ch, input logic [WIDTH-1:0] w, input string tag);
      for (int i = WIDTH - 1; i >= 0; i--) send_bit(ch, w[i], tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic async_reset(input string tag);
      rst = 1'b1;
      #1;
      m_reset();
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_data"},  32'(out_data),  0);
      chk({tag, "_chan"},  32'(out_chan),  0);
      chk({tag, "_ovf"},   32'(overflow),  0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      m_reset();
      #2;
      cmp_outputs("rst0");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single channel, latency
      out_ready = 1'b1;
      send_word(2, 8'hA5, "single");
      chk("single_lat_n", 32'(out_valid), 0);
      step("single");
      chk("single_valid", 32'(out_valid), 1);
      chk("single_data",  32'(out_data), 32'hA5);
      chk("single_chan",  32'(out_chan), 2);
      step("single");
      chk("single_pulse", 32'(out_valid), 0);

      // interleave
      got_q.delete();
      for (int i = WIDTH - 1; i >= 0; i--) begin
         logic [7:0] a, c;
         a = 8'h3C; c = 8'hC3;
         send_bit(0, a[i], "ilv");
         send_bit(1, c[i], "ilv");
      end
      idle(4, "ilv");
      chk("ilv_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("ilv_w0", 32'(got_q[0]), {22'd0, 2'd0, 8'h3C});
         chk("ilv_w1", 32'(got_q[1]), {22'd0, 2'd1, 8'hC3});
      end

      // round robin
      out_ready = 1'b0;
      send_word(0, 8'h11, "rr");
      send_word(1, 8'h22, "rr");
      send_word(2, 8'h33, "rr");
      send_word(3, 8'h44, "rr");
      idle(2, "rr");
      chk("rr_hold_data", 32'(out_data), 32'h11);
      chk("rr_hold_chan", 32'(out_chan), 0);
      out_ready = 1'b1;
      step("rr"); chk("rr_22", 32'(out_data), 32'h22);
      step("rr"); chk("rr_33", 32'(out_data), 32'h33);
      step("rr"); chk("rr_44", 32'(out_data), 32'h44);
      idle(2, "rr");

      // fairness: ch1 granted last, ch0 and ch2 pending -> ch2 first
      out_ready = 1'b0;
      send_word(1, 8'h55, "fair");
      send_word(0, 8'h66, "fair");
      send_word(2, 8'h77, "fair");
      idle(1, "fair");
      chk("fair_first_ch1", 32'(out_chan), 1);
      out_ready = 1'b1;
      step("fair"); chk("fair_ch2_data", 32'(out_data), 32'h77); chk("fair_ch2", 32'(out_chan), 2);
      step("fair"); chk("fair_ch0_data", 32'(out_data), 32'h66); chk("fair_ch0", 32'(out_chan), 0);
      idle(2, "fair");

      // overflow
      out_ready = 1'b0;
      send_word(3, 8'h01, "ovf");
      send_word(3, 8'h02, "ovf");
      send_word(3, 8'h03, "ovf");
      idle(2, "ovf");
      chk("ovf_flag", 32'(overflow), 32'h8);
      chk("ovf_out",  32'(out_data), 32'h01);
      clr_overflow = 1'b1;
      step("ovf");
      chk("ovf_clr", 32'(overflow), 0);
      got_q.delete();
      out_ready = 1'b1;
      idle(4, "ovf");
      chk("ovf_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("ovf_w0", 32'(got_q[0]), {22'd0, 2'd3, 8'h01});
         chk("ovf_w1", 32'(got_q[1]), {22'd0, 2'd3, 8'h02});
      end

      // reset mid-word
      send_bit(1, 1'b1, "rmw"); send_bit(1, 1'b0, "rmw"); send_bit(1, 1'b1, "rmw");
      send_bit(1, 1'b1, "rmw"); send_bit(1, 1'b0, "rmw");
      async_reset("rmw_rst");
      got_q.delete();
      send_word(1, 8'hFF, "rmw");
      idle(3, "rmw");
      chk("rmw_count", got_q.size(), 1);
      if (got_q.size() == 1) chk("rmw_word", 32'(got_q[0]), {22'd0, 2'd1, 8'hFF});

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bit_valid    = ($urandom_range(0, 3) != 0);
         sel          = 2'($urandom_range(0, 3));
         demux_out    = 4'($urandom_range(0, 15));
         out_ready    = ($urandom_range(0, 2) != 0);
         clr_overflow = ($urandom_range(0, 40) == 0);
         step("rnd");
         if (i == 1500) async_reset("rnd_rst");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
